// File: rtl/bin_to_bcd3_led7.sv
// ---------------------------------------------------------------------------
// bin_to_bcd3_led7
//   Registered display back end for the minute/second counter. Converts a
//   6-bit binary count (0-63) into two BCD digits with a shift-add-3 network
//   and drives two active-low 7-segment digits. Both outputs are registered
//   and update together with one cycle of latency.
//
//   Ports:
//     clk    in   1   system clock, rising edge
//     reset  in   1   synchronous, active-high reset
//     bin    in   6   binary value to display, 0-63
//     bcd    out  8   registered BCD value {tens[7:4], units[3:0]}
//     seg    out  14  registered segments, active-low
//                     {tens[13:7], units[6:0]}, bit 0 = a ... bit 6 = g
//
//   Build option:
//     BIN_TO_BCD3_LEADING_ZERO_BLANK_EN - blank the tens digit when it is 0.
//     The bcd output is unaffected by this option.
// ---------------------------------------------------------------------------

// Single-digit active-low 7-segment decoder; nibbles 10-15 show blank.
//   i_nibble  in   4   BCD digit
//   o_seg_c   out  7   active-low segments, bit 0 = a ... bit 6 = g
module bin_to_bcd3_led7_dec (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = 7'h7F;
    case (i_nibble)
      4'd0:    o_seg_c = 7'h40;
      4'd1:    o_seg_c = 7'h79;
      4'd2:    o_seg_c = 7'h24;
      4'd3:    o_seg_c = 7'h30;
      4'd4:    o_seg_c = 7'h19;
      4'd5:    o_seg_c = 7'h12;
      4'd6:    o_seg_c = 7'h02;
      4'd7:    o_seg_c = 7'h78;
      4'd8:    o_seg_c = 7'h00;
      4'd9:    o_seg_c = 7'h10;
      default: o_seg_c = 7'h7F;
    endcase
  end

endmodule

module bin_to_bcd3_led7 (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  bin,
  output logic [7:0]  bcd,
  output logic [13:0] seg
);

  localparam int unsigned BIN_W = 6;
  localparam int unsigned BCD_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DD_W  = BCD_W + BIN_W;

  logic [DD_W-1:0]  w_dd;
  logic [BCD_W-1:0] w_bcd;
  logic [SEG_W-1:0] w_seg_units;
  logic [SEG_W-1:0] w_seg_tens_raw;
  logic [SEG_W-1:0] w_seg_tens;

  logic [BCD_W-1:0]   r_bcd;
  logic [2*SEG_W-1:0] r_seg;

  // Double dabble: working register is {tens, units, bin}; before each left
  // shift, any BCD digit >= 5 gets +3 so the shift carries into the next digit.
  always_comb begin
    w_dd = {BCD_W'(0), bin};
    for (int unsigned i = 0; i < BIN_W; i++) begin
      if (w_dd[9:6] >= 4'd5)   w_dd[9:6]   = w_dd[9:6]   + 4'd3;
      if (w_dd[13:10] >= 4'd5) w_dd[13:10] = w_dd[13:10] + 4'd3;
      w_dd = {w_dd[DD_W-2:0], 1'b0};
    end
  end

  assign w_bcd = w_dd[DD_W-1:BIN_W];

  bin_to_bcd3_led7_dec u_dec_units (
    .i_nibble (w_bcd[3:0]),
    .o_seg_c  (w_seg_units)
  );

  bin_to_bcd3_led7_dec u_dec_tens (
    .i_nibble (w_bcd[7:4]),
    .o_seg_c  (w_seg_tens_raw)
  );

  // Optional leading-zero blanking of the tens digit.
`ifdef BIN_TO_BCD3_LEADING_ZERO_BLANK_EN
  assign w_seg_tens = (w_bcd[7:4] == 4'd0) ? 7'h7F : w_seg_tens_raw;
`else
  assign w_seg_tens = w_seg_tens_raw;
`endif

  // Output registers: both load every edge so bcd and seg always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd <= 8'h00;
      r_seg <= 14'h3FFF;
    end else begin
      r_bcd <= w_bcd;
      r_seg <= {w_seg_tens, w_seg_units};
    end
  end

  assign bcd = r_bcd;
  assign seg = r_seg;

endmodule

// File: tb/tb_bin_to_bcd3_led7.sv
module tb_bin_to_bcd3_led7;

  typedef struct packed {
    logic [5:0]  bin;
    logic [7:0]  bcd;
    logic [13:0] seg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [5:0]  bin;
  logic [7:0]  bcd;
  logic [13:0] seg;

  logic [3:0]  dec_nib;
  logic [6:0]  dec_seg;

  exp_t q[$];
  int   n_checks;
  int   n_fail;
  logic [6:0] seg_tbl [16];

  bin_to_bcd3_led7 dut (
    .clk   (clk),
    .reset (reset),
    .bin   (bin),
    .bcd   (bcd),
    .seg   (seg)
  );

  bin_to_bcd3_led7_dec u_dec (
    .i_nibble (dec_nib),
    .o_seg_c  (dec_seg)
  );

  // Clock starts high so the first edge seen is a falling edge (drive side).
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
    seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
    seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
    for (int k = 10; k < 16; k++) seg_tbl[k] = 7'h7F;
  end

  function automatic exp_t model(input logic rst, input int b);
    exp_t e;
    int   t;
    int   u;
    e.bin = 6'(b);
    if (rst) begin
      e.bcd = 8'h00;
      e.seg = 14'h3FFF;
    end else begin
      t = b / 10;
      u = b % 10;
      e.bcd = {4'(t), 4'(u)};
`ifdef BIN_TO_BCD3_LEADING_ZERO_BLANK_EN
      e.seg = {(t == 0) ? 7'h7F : seg_tbl[t], seg_tbl[u]};
`else
      e.seg = {seg_tbl[t], seg_tbl[u]};
`endif
    end
    return e;
  endfunction

  // Drive one cycle's input on the falling edge and queue its expected result.
  task automatic drive(input logic rst, input int b);
    @(negedge clk);
    reset = rst;
    bin   = 6'(b);
    q.push_back(model(rst, b));
  endtask

  // Monitor: every rising edge presents a new output; compare against queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bcd !== e.bcd) begin
          n_fail++;
          $display("FAIL bcd (bin=%0d): got %h expected %h at %0t", e.bin, bcd, e.bcd, $time);
        end
        n_checks++;
        if (seg !== e.seg) begin
          n_fail++;
          $display("FAIL seg (bin=%0d): got %h expected %h at %0t", e.bin, seg, e.seg, $time);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bin      = 6'd0;
    dec_nib  = 4'd0;

    // Reset held for three edges with arbitrary bin, then release with bin=0.
    for (int k = 0; k < 3; k++) drive(1'b1, int'($urandom_range(0, 63)));
    drive(1'b0, 0);
    drive(1'b0, 59);
    drive(1'b0, 63);
`ifdef BIN_TO_BCD3_LEADING_ZERO_BLANK_EN
    drive(1'b0, 7);
    drive(1'b0, 10);
`endif

    // Full sweep, one value per cycle, reset asserted while bin=45.
    for (int b = 0; b < 64; b++) drive(b == 45, b);

    // Random stream with occasional resets.
    for (int k = 0; k < 200; k++)
      drive($urandom_range(0, 15) == 0, int'($urandom_range(0, 63)));
    drive(1'b0, 0);

    // Drain scoreboard with a bound.
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    // Decoder unit test over all nibble values.
    for (int n = 0; n < 16; n++) begin
      dec_nib = 4'(n);
      #1;
      n_checks++;
      if (dec_seg !== seg_tbl[n]) begin
        n_fail++;
        $display("FAIL dec nibble %0d: got %h expected %h", n, dec_seg, seg_tbl[n]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
